// File: rtl/arriba_bus_if.sv
// Bus handshakes between the control unit and instruction memory,
// data memory and I/O ports.
interface arriba_bus_if #(
    parameter int ADR_W = 12
);
    logic [ADR_W-1:0] inst_adr_o;
    logic             inst_stb_o;
    logic             inst_ack_i;
    logic [7:0]       bus_adr_o;
    logic             data_stb_o;
    logic             data_we_o;
    logic             data_ack_i;
    logic             port_stb_o;
    logic             port_we_o;
    logic             port_ack_i;

    modport master (
        output inst_adr_o, inst_stb_o, bus_adr_o,
        output data_stb_o, data_we_o, port_stb_o, port_we_o,
        input  inst_ack_i, data_ack_i, port_ack_i
    );

    modport slave (
        input  inst_adr_o, inst_stb_o, bus_adr_o,
        input  data_stb_o, data_we_o, port_stb_o, port_we_o,
        output inst_ack_i, data_ack_i, port_ack_i
    );
endinterface

// File: rtl/arriba_control_unit.sv
// Instruction-sequencing control unit: owns PC and return stack, runs the
// bus handshakes and drives the datapath controls.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_FETCH   | instruction request at pc, wait for inst_ack_i
// S_DECODE  | decoded fields valid; dispatch, resolve branch/jump/ret
// S_EXECUTE | ALU/shift writeback, flags captured
// S_MEM     | data or port cycle, held until the matching ack
// S_HALT    | halted, waiting for wake_i
module arriba_control_unit #(
    parameter int              PC_W        = 12,
    parameter int              STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    arriba_bus_if.master     bus,
    input  logic [6:0]       op_e,
    input  logic [2:0]       func_e,
    input  logic [PC_W-1:0]  addr_e,
    input  logic [7:0]       disp_e,
    input  logic [7:0]       offset_e,
    input  logic [7:0]       rs_i,
    input  logic             zero_e,
    input  logic             carry_e,
    input  logic             wake_i,
    output logic             RegWrt_c,
    output logic             ClkEn_e,
    output logic [1:0]       RegMux_c,
    output logic             op2_c,
    output logic [3:0]       ALUOp_c,
    output logic             halt_o
);
    localparam int SP_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic            push;
    logic            z_q, z_d, c_q, c_d;
    logic [7:0]      adr_q, adr_d;
    logic [2:0]      func_q, func_d;
    logic            shift_q, shift_d;
    logic            imm_q, imm_d;

    logic            one_hot;
    logic            br_taken;
    logic [SP_W-1:0] sp_dec;
    logic            mem_ack;
    logic            mem_load;
    logic            inst_stb;

    assign one_hot = (op_e != 7'd0) && ((op_e & (op_e - 7'd1)) == 7'd0);
    assign sp_dec  = sp_q - {{(SP_W-1){1'b0}}, 1'b1};

    // Branch condition against the registered flags.
    always_comb begin
        br_taken = 1'b0;
        case (func_e[1:0])
            2'b00:   br_taken = z_q;
            2'b01:   br_taken = !z_q;
            2'b10:   br_taken = c_q;
            default: br_taken = !c_q;
        endcase
    end

    // State, PC, stack pointer, flags and latched instruction fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            sp_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            adr_q   <= '0;
            func_q  <= '0;
            shift_q <= 1'b0;
            imm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            z_q     <= z_d;
            c_q     <= c_d;
            adr_q   <= adr_d;
            func_q  <= func_d;
            shift_q <= shift_d;
            imm_q   <= imm_d;
        end
    end

    // Return stack storage; cleared at reset so an empty-stack ret is defined.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else if (push) begin
            stack_q[sp_q] <= pc_q;
        end
    end

    // Next-state logic and Moore outputs (load writeback gated by ack).
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        push     = 1'b0;
        z_d      = z_q;
        c_d      = c_q;
        adr_d    = adr_q;
        func_d   = func_q;
        shift_d  = shift_q;
        imm_d    = imm_q;
        inst_stb = 1'b0;
        mem_ack  = 1'b0;
        mem_load = 1'b0;
        bus.bus_adr_o  = 8'd0;
        bus.data_stb_o = 1'b0;
        bus.data_we_o  = 1'b0;
        bus.port_stb_o = 1'b0;
        bus.port_we_o  = 1'b0;
        RegWrt_c = 1'b0;
        ClkEn_e  = 1'b0;
        RegMux_c = 2'b00;
        op2_c    = 1'b0;
        ALUOp_c  = 4'b0000;
        halt_o   = 1'b0;

        case (state_q)
            S_FETCH: begin
                inst_stb = 1'b1;
                if (bus.inst_ack_i) begin
                    pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                func_d  = func_e;
                shift_d = op_e[2];
                imm_d   = op_e[1];
                state_d = S_FETCH;
                if (one_hot) begin
                    if (op_e[0] || op_e[1] || op_e[2]) begin
                        state_d = S_EXECUTE;
                    end else if (op_e[3]) begin
                        adr_d   = rs_i + offset_e;
                        state_d = S_MEM;
                    end else if (op_e[4]) begin
                        if (br_taken)
                            pc_d = pc_q + {{(PC_W-8){disp_e[7]}}, disp_e};
                    end else if (op_e[5]) begin
                        if (func_e[0]) begin
                            push = 1'b1;
                            sp_d = sp_q + {{(SP_W-1){1'b0}}, 1'b1};
                        end
                        pc_d = addr_e;
                    end else begin
                        if (func_e == 3'b000) begin
                            sp_d = sp_dec;
                            pc_d = stack_q[sp_dec];
                        end else if (func_e[2:1] == 2'b10) begin
                            state_d = S_HALT;
                        end
                    end
                end
            end

            S_EXECUTE: begin
                RegWrt_c = 1'b1;
                ClkEn_e  = 1'b1;
                ALUOp_c  = shift_q ? {2'b10, func_q[1:0]} : {1'b0, func_q};
                op2_c    = !imm_q;
                z_d      = zero_e;
                c_d      = carry_e;
                state_d  = S_FETCH;
            end

            S_MEM: begin
                if (func_q[2]) begin
                    state_d = S_FETCH;
                end else begin
                    bus.bus_adr_o = adr_q;
                    mem_load      = !func_q[0];
                    if (func_q[1]) begin
                        bus.port_stb_o = 1'b1;
                        bus.port_we_o  = func_q[0];
                        mem_ack        = bus.port_ack_i;
                        RegMux_c       = mem_load ? 2'b10 : 2'b00;
                    end else begin
                        bus.data_stb_o = 1'b1;
                        bus.data_we_o  = func_q[0];
                        mem_ack        = bus.data_ack_i;
                        RegMux_c       = mem_load ? 2'b01 : 2'b00;
                    end
                    if (mem_ack) begin
                        RegWrt_c = mem_load;
                        ClkEn_e  = mem_load;
                        state_d  = S_FETCH;
                    end
                end
            end

            S_HALT: begin
                halt_o = 1'b1;
                if (wake_i) state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // Reset holds FETCH, but no request may go out while rst_i is high.
    assign bus.inst_stb_o = inst_stb && !rst_i;
    assign bus.inst_adr_o = pc_q;
endmodule

// File: tb/tb_arriba_control_unit.sv
// Self-checking bench for arriba_control_unit: directed instruction table,
// nested-call and reset-abort sequences, then random instruction streams
// checked against an instruction-level reference model.
module tb_arriba_control_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  op_e = '0;
    logic [2:0]  func_e = '0;
    logic [11:0] addr_e = '0;
    logic [7:0]  disp_e = '0, offset_e = '0, rs_i = '0;
    logic        zero_e = 1'b0, carry_e = 1'b0, wake_i = 1'b0;
    logic        RegWrt_c, ClkEn_e, op2_c, halt_o;
    logic [1:0]  RegMux_c;
    logic [3:0]  ALUOp_c;

    arriba_bus_if #(.ADR_W(12)) bus ();

    arriba_control_unit dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .op_e(op_e), .func_e(func_e), .addr_e(addr_e), .disp_e(disp_e),
        .offset_e(offset_e), .rs_i(rs_i), .zero_e(zero_e), .carry_e(carry_e),
        .wake_i(wake_i), .RegWrt_c(RegWrt_c), .ClkEn_e(ClkEn_e),
        .RegMux_c(RegMux_c), .op2_c(op2_c), .ALUOp_c(ALUOp_c), .halt_o(halt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: architectural state at instruction granularity.
    int m_pc;
    int m_sp;
    int m_stack [8];
    bit m_z, m_c;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  func;
        logic [11:0] addr;
        logic [7:0]  disp;
        logic [7:0]  off;
        logic [7:0]  rs;
        bit          zero;
        bit          carry;
        int          dly;
        logic [11:0] exp_next;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_sp = 0;
        m_z  = 0;
        m_c  = 0;
        for (int i = 0; i < 8; i++) m_stack[i] = 0;
    endtask

    task automatic wait_fetch();
        int n;
        n = 0;
        while (bus.inst_stb_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("fetch_timeout", {31'd0, bus.inst_stb_o}, 32'd1);
    endtask

    // Runs one instruction through fetch, decode and any execute/mem/halt
    // cycles, checking outputs against the model and updating it.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] func,
                             input logic [11:0] addr, input logic [7:0] disp,
                             input logic [7:0] off, input logic [7:0] rs,
                             input bit zero, input bit carry,
                             input int dly, input int idly);
        int  sdisp;
        bit  taken, load, is_port;
        logic [3:0] exp_op;
        wait_fetch();
        if (bus.inst_stb_o !== 1'b1) return;
        chk("fetch_adr", {20'd0, bus.inst_adr_o}, m_pc);
        for (int i = 0; i < idly; i++) begin
            step();
            chk("fetch_hold", {19'd0, bus.inst_stb_o, bus.inst_adr_o}, {19'd0, 1'b1, 12'(m_pc)});
        end
        op_e = op; func_e = func; addr_e = addr; disp_e = disp;
        offset_e = off; rs_i = rs; zero_e = zero; carry_e = carry;
        bus.inst_ack_i = 1'b1;
        step();
        bus.inst_ack_i = 1'b0;
        m_pc = (m_pc + 1) % 4096;
        chk("decode_quiet", {28'd0, RegWrt_c, bus.inst_stb_o, bus.data_stb_o, bus.port_stb_o}, 32'd0);
        step();

        if ($countones(op) != 1) begin
            // not one-hot: nop
        end else if (op[0] || op[1] || op[2]) begin
            exp_op = op[2] ? {2'b10, func[1:0]} : {1'b0, func};
            chk("exec_regwrt", {31'd0, RegWrt_c}, 1);
            chk("exec_clken", {31'd0, ClkEn_e}, 1);
            chk("exec_aluop", {28'd0, ALUOp_c}, {28'd0, exp_op});
            chk("exec_op2", {31'd0, op2_c}, op[1] ? 0 : 1);
            chk("exec_regmux", {30'd0, RegMux_c}, 0);
            step();
            chk("exec_one_cycle", {31'd0, RegWrt_c}, 0);
            m_z = zero;
            m_c = carry;
        end else if (op[3]) begin
            if (func[2]) begin
                chk("memnop_stb", {30'd0, bus.data_stb_o, bus.port_stb_o}, 0);
                step();
            end else begin
                is_port = func[1];
                load    = !func[0];
                for (int d = 0; d <= dly; d++) begin
                    chk("mem_stb", {30'd0, bus.data_stb_o, bus.port_stb_o},
                        is_port ? 32'd1 : 32'd2);
                    chk("mem_we", {31'd0, is_port ? bus.port_we_o : bus.data_we_o}, func[0]);
                    chk("mem_adr", {24'd0, bus.bus_adr_o}, (rs + off) % 256);
                    if (d == dly) begin
                        if (is_port) bus.port_ack_i = 1'b1; else bus.data_ack_i = 1'b1;
                        #1;
                        chk("mem_ack_regwrt", {30'd0, RegWrt_c, ClkEn_e}, load ? 3 : 0);
                        if (load) chk("mem_regmux", {30'd0, RegMux_c}, is_port ? 2 : 1);
                    end else begin
                        chk("mem_wait_regwrt", {31'd0, RegWrt_c}, 0);
                    end
                    step();
                    bus.data_ack_i = 1'b0;
                    bus.port_ack_i = 1'b0;
                end
            end
        end else if (op[4]) begin
            case (func[1:0])
                2'b00: taken = m_z;
                2'b01: taken = !m_z;
                2'b10: taken = m_c;
                default: taken = !m_c;
            endcase
            sdisp = disp[7] ? int'(disp) - 256 : int'(disp);
            if (taken) m_pc = (m_pc + sdisp + 4096) % 4096;
        end else if (op[5]) begin
            if (func[0]) begin
                m_stack[m_sp] = m_pc;
                m_sp = (m_sp + 1) % 8;
            end
            m_pc = addr;
        end else begin
            if (func == 3'b000) begin
                m_sp = (m_sp + 7) % 8;
                m_pc = m_stack[m_sp];
            end else if (func == 3'b100 || func == 3'b101) begin
                chk("halt_on", {30'd0, halt_o, bus.inst_stb_o}, 2);
                for (int i = 0; i < dly; i++) begin
                    step();
                    chk("halt_hold", {30'd0, halt_o, bus.inst_stb_o}, 2);
                end
                wake_i = 1'b1;
                step();
                wake_i = 1'b0;
                chk("halt_off", {31'd0, halt_o}, 0);
            end
        end
    endtask

    initial begin
        // op classes
        logic [6:0] ALR, ALI, SHF, MEM, BRA, JMP, MSC;
        int exp_ret;
        ALR = 7'h01; ALI = 7'h02; SHF = 7'h04; MEM = 7'h08;
        BRA = 7'h10; JMP = 7'h20; MSC = 7'h40;

        tbl[0]  = '{ALR, 3'b000, 12'h000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h001};
        tbl[1]  = '{ALR, 3'b000, 12'h000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h002};
        tbl[2]  = '{JMP, 3'b000, 12'h00F, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h00F};
        tbl[3]  = '{ALI, 3'b000, 12'h000, 8'h00, 8'h00, 8'h00, 1, 0, 0, 12'h010};
        tbl[4]  = '{BRA, 3'b000, 12'h000, 8'hFC, 8'h00, 8'h00, 0, 0, 0, 12'h00D};
        tbl[5]  = '{JMP, 3'b000, 12'h00F, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h00F};
        tbl[6]  = '{ALI, 3'b000, 12'h000, 8'h00, 8'h00, 8'h00, 1, 0, 0, 12'h010};
        tbl[7]  = '{BRA, 3'b001, 12'h000, 8'hFC, 8'h00, 8'h00, 0, 0, 0, 12'h011};
        tbl[8]  = '{JMP, 3'b000, 12'h050, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h050};
        tbl[9]  = '{JMP, 3'b001, 12'h200, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h200};
        tbl[10] = '{MSC, 3'b000, 12'h000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h051};
        tbl[11] = '{MEM, 3'b000, 12'h000, 8'h00, 8'h20, 8'hF0, 0, 0, 3, 12'h052};
        tbl[12] = '{MEM, 3'b011, 12'h000, 8'h00, 8'h05, 8'h11, 0, 0, 0, 12'h053};
        tbl[13] = '{MSC, 3'b100, 12'h000, 8'h00, 8'h00, 8'h00, 0, 0, 3, 12'h054};
        tbl[14] = '{BRA, 3'b010, 12'h000, 8'h10, 8'h00, 8'h00, 0, 0, 0, 12'h055};
        tbl[15] = '{ALR, 3'b001, 12'h000, 8'h00, 8'h00, 8'h00, 0, 1, 0, 12'h056};
        tbl[16] = '{BRA, 3'b010, 12'h000, 8'h10, 8'h00, 8'h00, 0, 0, 0, 12'h067};
        tbl[17] = '{BRA, 3'b011, 12'h000, 8'hFE, 8'h00, 8'h00, 0, 0, 0, 12'h068};
        tbl[18] = '{7'h03, 3'b000, 12'h000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h069};
        tbl[19] = '{SHF, 3'b101, 12'h000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h06A};
        tbl[20] = '{JMP, 3'b000, 12'hFFF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'hFFF};
        tbl[21] = '{MSC, 3'b001, 12'h000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 12'h000};
        tbl[22] = '{BRA, 3'b001, 12'h000, 8'h80, 8'h00, 8'h00, 0, 0, 0, 12'hF81};

        bus.inst_ack_i = 1'b0;
        bus.data_ack_i = 1'b0;
        bus.port_ack_i = 1'b0;
        model_reset();

        // Reset values while rst is held.
        #12;
        chk("rst_strobes", {27'd0, bus.inst_stb_o, bus.data_stb_o, bus.port_stb_o,
                            bus.data_we_o, bus.port_we_o}, 0);
        chk("rst_ctrl", {28'd0, RegWrt_c, ClkEn_e, halt_o, op2_c}, 0);
        chk("rst_mux_op", {26'd0, RegMux_c, ALUOp_c}, 0);
        chk("rst_busadr", {24'd0, bus.bus_adr_o}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_first_fetch", {19'd0, bus.inst_stb_o, bus.inst_adr_o}, {19'd0, 1'b1, 12'h000});

        // Directed instruction table.
        for (int i = 0; i < 23; i++) begin
            run_instr(tbl[i].op, tbl[i].func, tbl[i].addr, tbl[i].disp, tbl[i].off,
                      tbl[i].rs, tbl[i].zero, tbl[i].carry, tbl[i].dly, 0);
            wait_fetch();
            chk($sformatf("tbl%0d_next_pc", i), {20'd0, bus.inst_adr_o}, {20'd0, tbl[i].exp_next});
        end

        // Nine nested calls overflow the 8-deep stack; the oldest slot is reused.
        run_instr(JMP, 3'b000, 12'h100, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++)
            run_instr(JMP, 3'b001, 12'(12'h110 + 16 * k), 0, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 9; j++) begin
            run_instr(MSC, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
            wait_fetch();
            exp_ret = (j == 9) ? 12'h181 : 12'h101 + 16 * (9 - j);
            chk($sformatf("ret%0d_adr", j), {20'd0, bus.inst_adr_o}, exp_ret);
        end

        // Random instruction stream against the model.
        for (int n = 0; n < 200; n++) begin
            logic [6:0] op;
            int cls;
            cls = $urandom_range(0, 7);
            op = (cls == 7) ? 7'($urandom_range(0, 127) | 7'h03) & 7'h7B : 7'(1 << cls);
            if ($countones(op) == 1 && cls == 7) op = 7'h0;
            run_instr(op, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        wait_fetch();
        chk("rand_final_pc", {20'd0, bus.inst_adr_o}, m_pc);

        // Reset in the middle of a held data cycle.
        op_e = MEM; func_e = 3'b000; rs_i = 8'h01; offset_e = 8'h02;
        bus.inst_ack_i = 1'b1;
        step();
        bus.inst_ack_i = 1'b0;
        step();
        chk("abort_pre_stb", {31'd0, bus.data_stb_o}, 1);
        step();
        chk("abort_held_stb", {31'd0, bus.data_stb_o}, 1);
        rst = 1'b1;
        #1;
        chk("abort_stb_drop", {30'd0, bus.data_stb_o, bus.inst_stb_o}, 0);
        step();
        rst = 1'b0;
        #1;
        model_reset();
        chk("abort_refetch", {19'd0, bus.inst_stb_o, bus.inst_adr_o}, {19'd0, 1'b1, 12'h000});
        run_instr(ALR, 3'b010, 0, 0, 0, 0, 0, 0, 0, 1);
        wait_fetch();
        chk("abort_resume_pc", {20'd0, bus.inst_adr_o}, m_pc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/arriba_control_unit.md
Name: arriba_control_unit

Overview:
Instruction-sequencing control unit that sits directly upstream of the datapath (instruction register, register bank, ALU, carry flip-flop). Owns the 12-bit PC and an 8-entry return stack. Runs the instruction/data/port bus handshakes and consumes the decoded fields and ALU flags coming back from the datapath. Drives the datapath controls: RegWrt_c, ClkEn_e, RegMux_c, op2_c and ALUOp_c.

Parameters:
PC_W, 12, PC and instruction-address width
STACK_DEPTH, 8, return-stack entries (power of 2)
RESET_PC, 12'h000, PC value loaded at reset

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
op_e  in  7  decoded class, one-hot: [0]ALU-reg [1]ALU-imm [2]shift [3]mem [4]branch [5]jump [6]misc
func_e  in  3  sub-operation within class
addr_e  in  12  jump target
disp_e  in  8  branch displacement, two's complement
offset_e  in  8  memory/port address offset
rs_i  in  8  rs register value (datapath rs_o)
zero_e, carry_e  in  1 each  combinational ALU flags
inst_ack_i, data_ack_i, port_ack_i  in  1 each  bus acknowledges
wake_i  in  1  exits HALT
inst_adr_o  out  12  instruction address
inst_stb_o  out  1  instruction request
bus_adr_o  out  8  data/port address
data_stb_o, data_we_o  out  1 each  data-memory request / write
port_stb_o, port_we_o  out  1 each  I/O-port request / write
RegWrt_c, ClkEn_e  out  1 each  register write / datapath clock enable
RegMux_c  out  2  writeback source: 00 ALU, 01 data_dat_i, 10 port_dat_i
op2_c  out  1  ALU operand 2: 1 rs2, 0 immediate
ALUOp_c  out  4  ALU operation
halt_o  out  1  high in HALT

Behaviour:
- Reset (async, while rst_i=1):
  - State FETCH, pc=RESET_PC, sp=0, registered Z=C=0.
  - All strobes, RegWrt_c, ClkEn_e and halt_o are 0.
  - RegMux_c=00, op2_c=0, ALUOp_c=0000, bus_adr_o=0.
  - Reset mid-bus-cycle abandons the cycle immediately.
- All outputs are Moore outputs except RegWrt_c/ClkEn_e in MEM; they are 0 in any state not listed below.
- FETCH:
  - inst_stb_o=1, inst_adr_o=pc.
  - Hold until inst_ack_i. On ack: pc<=pc+1 (mod 2^PC_W), go to DECODE.
  - The datapath latches the instruction on the same edge.
- DECODE (1 cycle; decoded fields are valid), dispatch on op_e:
  - ALU-reg / ALU-imm / shift -> EXECUTE.
  - mem -> MEM, with bus_adr_o<=rs_i+offset_e (8-bit wrap).
  - branch, func_e[1:0] selects the condition: 00 bz (Z), 01 bnz (!Z), 10 bc (C), 11 bnc (!C).
    - Taken: pc<=pc+sext(disp_e) mod 4096. Next state FETCH.
  - jump, func_e[0]: 0 jmp: pc<=addr_e. 1 jsr: stack[sp]<=pc, sp<=sp+1, pc<=addr_e. Next state FETCH.
  - misc, func_e: 000 ret: sp<=sp-1, pc<=stack[sp-1], then FETCH. 100 wait / 101 stby: HALT. Others: nop, FETCH.
  - op_e not one-hot: treat as nop, FETCH.
- EXECUTE (1 cycle), then FETCH:
  - RegWrt_c=1, ClkEn_e=1, RegMux_c=00.
  - ALUOp_c={0,func_e} for ALU classes; {2'b10,func_e[1:0]} for shift.
  - op2_c=0 for ALU-imm, 1 otherwise.
  - Z<=zero_e, C<=carry_e.
- MEM, func_e selects the operation:
  - 000 ldm: data_stb_o=1, data_we_o=0.
  - 001 stm: data_stb_o=1, data_we_o=1.
  - 010 inp: port_stb_o=1, port_we_o=0.
  - 011 out: port_stb_o=1, port_we_o=1.
  - 1xx: nop, FETCH next cycle.
  - Strobe, we and bus_adr_o are held stable until the matching ack.
  - Load ack cycle: RegWrt_c=1 and ClkEn_e=1 combinationally; RegMux_c=01 (ldm) or 10 (inp). Register written on the ack edge.
  - Any ack -> FETCH. Z/C are unchanged.
- HALT: halt_o=1, no strobes; wake_i=1 -> FETCH (pc already advanced).
- Return stack:
  - Push past STACK_DEPTH wraps sp and silently overwrites the oldest entry.
  - ret on an empty stack wraps sp and returns the stale entry; no error flag.
- Timing: minimum instruction time with zero-wait acks is ALU 3 cycles, branch/jump 2, load/store 3.

Test Plan:
- Reset, then inst_ack_i asserted the same cycle as inst_stb_o -> inst_adr_o 0,1,2 on successive fetches; ALU-reg add (func 000) gives ALUOp_c=0000, op2_c=1, RegWrt_c=ClkEn_e=1 for exactly one cycle.
- ALU-imm with zero_e=1, then bz disp_e=8'hFC at fetch address 0x010 -> next inst_adr_o=0x00D; same sequence with bnz -> 0x011.
- jsr addr_e=0x200 at fetch address 0x050, then ret at 0x200 -> fetch 0x200, then 0x051; nine nested jsr then nine ret -> ninth ret returns the first-pushed value is not guaranteed; last ret returns the most recent overwrite.
- ldm with rs_i=8'hF0, offset_e=8'h20, data_ack_i delayed 3 cycles -> bus_adr_o=8'h10 with data_stb_o held 4 cycles; RegMux_c=01 and RegWrt_c=1 only in the ack cycle.
- out with port_ack_i immediate -> port_stb_o=port_we_o=1 for one cycle, RegWrt_c never asserted; wait -> halt_o=1 until wake_i, then fetch resumes at pc+1.
- Assert rst_i mid-MEM while data_stb_o=1 -> data_stb_o drops asynchronously; after release the first fetch is at 0x000.
